// File: rtl/rgb_pixel_out.sv
// Pixel output stage: turns a raster timing stream plus a frame-buffer read FIFO
// into RGB888 video with a fixed two-cycle latency, or shows colour bars instead.
module rgb_pixel_out #(
  parameter logic [23:0] FILL_RGB = 24'h000000,
  parameter int          H_ACTIVE = 1280
) (
  input  logic        rgb_clk,
  input  logic        rgb_rst_n,
  input  logic        rgb_hs,
  input  logic        rgb_vs,
  input  logic        rgb_de,
  input  logic [10:0] rgb_x,
  input  logic        pattern_en,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        frame_req,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_de,
  output logic [23:0] out_rgb,
  output logic        underflow,
  output logic [7:0]  underflow_cnt
);

  localparam int BAR_W = H_ACTIVE / 8;

  typedef enum logic [1:0] {IDLE, STREAM, RESYNC} state_t;
  typedef enum logic [1:0] {SRC_FILL, SRC_FIFO, SRC_BAR} src_t;

  state_t      state;
  state_t      state_next;
  logic        vs_q;
  logic        vs_armed;
  logic        fs;
  logic        frame_pattern;
  logic        uf_event;
  logic [2:0]  bar_idx;
  src_t        src_sel;

  logic        hs_d1;
  logic        vs_d1;
  logic        de_d1;
  src_t        src_d1;
  logic [2:0]  bar_d1;
  logic [23:0] rgb_pre;

  // vs_armed blocks a false frame start when rgb_vs is already high as reset
  // releases: a real rising edge needs rgb_vs to be seen low first.
  assign fs = rgb_vs & ~vs_q & vs_armed;

  // FIFO read handshake: the word is consumed in the cycle fifo_rd_en is high
  // (only ever with rgb_de=1 and fifo_empty=0); it appears on fifo_dout one
  // cycle later.
  always_comb begin
    state_next = state;
    fifo_rd_en = 1'b0;
    uf_event   = 1'b0;
    case (state)
      IDLE:   if (fs) state_next = STREAM;
      RESYNC: if (fs) state_next = STREAM;
      STREAM: begin
        if (!frame_pattern && rgb_de) begin
          if (fifo_empty) begin
            uf_event   = 1'b1;
            state_next = RESYNC;
          end else begin
            fifo_rd_en = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (!rgb_rst_n) begin
      fifo_rd_en = 1'b0;
      uf_event   = 1'b0;
      state_next = IDLE;
    end
  end

  always_ff @(posedge rgb_clk) begin
    if (!rgb_rst_n) begin
      state         <= IDLE;
      vs_q          <= 1'b0;
      vs_armed      <= 1'b0;
      frame_req     <= 1'b0;
      frame_pattern <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= 8'd0;
    end else begin
      state     <= state_next;
      vs_q      <= rgb_vs;
      vs_armed  <= vs_armed | ~rgb_vs;
      frame_req <= fs;
      if (fs) frame_pattern <= pattern_en;
      if (fs && underflow && underflow_cnt != 8'hFF)
        underflow_cnt <= underflow_cnt + 8'd1;
      // an underflow in the frame-start cycle wins over the clear
      if (uf_event)
        underflow <= 1'b1;
      else if (fs)
        underflow <= 1'b0;
    end
  end

  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(rgb_x) >= k * BAR_W) bar_idx = bar_idx + 3'd1;
    end
  end

  always_comb begin
    if (frame_pattern)   src_sel = SRC_BAR;
    else if (fifo_rd_en) src_sel = SRC_FIFO;
    else                 src_sel = SRC_FILL;
  end

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Stage 1 carries timing and the pixel source while the FIFO word is in flight.
  always_ff @(posedge rgb_clk) begin
    if (!rgb_rst_n) begin
      hs_d1  <= 1'b0;
      vs_d1  <= 1'b0;
      de_d1  <= 1'b0;
      src_d1 <= SRC_FILL;
      bar_d1 <= 3'd0;
    end else begin
      hs_d1  <= rgb_hs;
      vs_d1  <= rgb_vs;
      de_d1  <= rgb_de;
      src_d1 <= src_sel;
      bar_d1 <= bar_idx;
    end
  end

  always_comb begin
    case (src_d1)
      SRC_FIFO: rgb_pre = {fifo_dout[15:11], fifo_dout[15:13],
                           fifo_dout[10:5],  fifo_dout[10:9],
                           fifo_dout[4:0],   fifo_dout[4:2]};
      SRC_BAR:  rgb_pre = bar_colour(bar_d1);
      default:  rgb_pre = FILL_RGB;
    endcase
  end

  always_ff @(posedge rgb_clk) begin
    if (!rgb_rst_n) begin
      out_hs  <= 1'b0;
      out_vs  <= 1'b0;
      out_de  <= 1'b0;
      out_rgb <= 24'h000000;
    end else begin
      out_hs  <= hs_d1;
      out_vs  <= vs_d1;
      out_de  <= de_d1;
      out_rgb <= de_d1 ? rgb_pre : 24'h000000;
    end
  end

endmodule

// File: doc/rgb_pixel_out.md
RGB_PIXEL_OUT -- requirements
Module: rgb_pixel_out

Interface
REQ-001 SHALL have parameter FILL_RGB, default 24'h000000: colour driven for any active pixel not sourced from the FIFO.
REQ-002 SHALL have parameter H_ACTIVE, default 1280: active width used for colour-bar boundaries.
REQ-003 SHALL have ports as listed; rgb_clk is the single clock, and rgb_rst_n is a synchronous, active-low reset:
- rgb_clk  in  1  pixel clock
- rgb_rst_n  in  1  synchronous reset, active-low
- rgb_hs  in  1  horizontal sync from the timing generator
- rgb_vs  in  1  vertical sync from the timing generator, active-high
- rgb_de  in  1  active-video flag
- rgb_x  in  11  pixel column
- pattern_en  in  1  selects colour bars instead of FIFO data; sampled at frame start
- fifo_dout  in  16  RGB565 pixel from the frame-buffer read FIFO (first-word-fall-through off)
- fifo_empty  in  1  read FIFO empty
- fifo_rd_en  out  1  FIFO read strobe
- frame_req  out  1  one-cycle pulse asking the frame reader to start a new frame
- out_hs  out  1  delayed rgb_hs
- out_vs  out  1  delayed rgb_vs
- out_de  out  1  delayed rgb_de
- out_rgb  out  24  RGB888 pixel
- underflow  out  1  sticky flag for the current frame
- underflow_cnt  out  8  count of frames containing an underflow

Function
REQ-004 SHALL define frame start (FS) as the rising edge of rgb_vs, detected with a registered copy of rgb_vs.
REQ-005 SHALL implement FSM states IDLE, STREAM and RESYNC.
REQ-006 In IDLE: no FIFO reads; active pixels output FILL_RGB; on FS go to STREAM.
REQ-007 In STREAM with pattern mode off: fifo_rd_en = rgb_de & ~fifo_empty, combinational, same cycle.
REQ-008 In STREAM, if rgb_de=1 and fifo_empty=1 in the same cycle (underflow):
- no read is issued
- that pixel outputs FILL_RGB
- underflow is set
- the next state is RESYNC
REQ-009 In RESYNC: no FIFO reads; all active pixels output FILL_RGB; on FS go to STREAM.
REQ-010 On every FS, in any state:
- frame_req pulses high for exactly one cycle
- pattern_en is latched as frame_pattern
- underflow is cleared
REQ-011 If underflow was 1 at FS, underflow_cnt SHALL increment by one, saturating at 255.
REQ-012 If FS and an underflow occur in the same cycle, the FS actions SHALL apply first and underflow SHALL then be set, so the flag ends at 1.
REQ-013 With frame_pattern=1: no FIFO reads in any state; active pixels show 8 vertical bars, each H_ACTIVE/8 wide (bar = rgb_x / (H_ACTIVE/8), computed with comparators, no divider).
- Bar colours in order: white, yellow, cyan, green, magenta, red, blue, black.
- Underflow detection is disabled.
REQ-014 SHALL expand RGB565 to RGB888 as R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}.
REQ-015 SHALL give out_hs, out_vs, out_de and out_rgb a fixed latency of exactly 2 rgb_clk cycles relative to rgb_hs, rgb_vs, rgb_de and rgb_x.
- Pixel data read in cycle n SHALL appear on out_rgb in cycle n+2, aligned with out_de.
REQ-016 SHALL force out_rgb to 24'h000000 whenever out_de=0.
REQ-017 fifo_rd_en SHALL never assert when fifo_empty=1 or rgb_de=0.

Reset
REQ-018 While rgb_rst_n=0, sampled on rgb_clk, SHALL hold:
- state=IDLE
- fifo_rd_en=0, frame_req=0
- out_hs=out_vs=out_de=0, out_rgb=0
- underflow=0, underflow_cnt=0
- frame_pattern=0
- vs edge register=0
- both delay-pipeline stages cleared
REQ-019 Reset asserted mid-frame SHALL abort streaming; after release, the block SHALL stay in IDLE until the next FS, even if rgb_vs is already high.

Verification
REQ-020 Reset, then release with rgb_vs low; drive one full 1280x720 frame with a pre-filled FIFO -> no fifo_rd_en before the first FS; frame_req pulses once; the second frame reads exactly 921600 words.
REQ-021 FIFO word 16'hF800 read at the first pixel -> out_rgb=24'hFF0000 exactly 2 cycles later with out_de=1; out_hs/out_vs equal the inputs delayed by 2 cycles.
REQ-022 FIFO empties at pixel x=100 of line 10 -> that pixel and the rest of the frame output FILL_RGB with no further reads; underflow=1; at next FS underflow_cnt=1, underflow=0, and streaming resumes.
REQ-023 pattern_en=1 before FS -> x=0 gives FFFFFF, x=160 gives FFFF00, x=1279 gives 000000; fifo_rd_en stays 0; toggling pattern_en mid-frame has no effect until the next FS.
REQ-024 Force 300 consecutive frames with an underflow -> underflow_cnt saturates at 255.
REQ-025 Assert rgb_rst_n=0 for 3 cycles mid-line -> all outputs 0; after release, no read until the next FS.
